// File: rtl/ps2_host_pkg.sv
// Shared frame constants and state encoding for the PS/2 host receive path.
package ps2_host_pkg;
  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_CNT_W     = 4;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Receive FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
endpackage

// File: rtl/ps2_host_rx_shifter.sv
// Data shift register, bit counter and running parity for the PS/2 receiver.
// The parity output exists only when PS2_HOST_RX_PARITY_CHECK_EN is defined.
module ps2_host_rx_shifter
  import ps2_host_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     shift,
  input  logic                     din,
  output logic [PS2_DATA_BITS-1:0] data,
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
  output logic                     parity,
`endif
  output logic                     done
);

  logic [PS2_CNT_W-1:0] count;

  // done flags that the shift happening now delivers the final data bit
  assign done = (count == PS2_CNT_W'(PS2_DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift) begin
      data  <= {din, data[PS2_DATA_BITS-1:1]};
      count <= count + 1'b1;
    end
  end

`ifdef PS2_HOST_RX_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || clear)
      parity <= 1'b0;
    else if (shift)
      parity <= parity ^ din;
  end
`endif

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host frame receiver with a valid/ready byte output register.
// Parity checking is compiled in only when PS2_HOST_RX_PARITY_CHECK_EN is defined.
module ps2_host_rx
  import ps2_host_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  input  logic       watchdog_rst,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  logic [1:0]               state;
  logic                     sample;
  logic                     start;
  logic [PS2_DATA_BITS-1:0] sh_data;
  logic                     sh_done;
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
  logic                     sh_par;
  logic                     par_bit;
`endif

  // A watchdog abort in the same cycle as a strobe discards that sample
  assign sample  = ps2_clk_negedge & ~watchdog_rst;
  assign start   = sample && (state == ST_IDLE) && (ps2_data == PS2_START_BIT);
  assign rx_busy = (state != ST_IDLE);

  ps2_host_rx_shifter u_shifter (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (watchdog_rst | start),
    .shift  (sample && (state == ST_DATA)),
    .din    (ps2_data),
    .data   (sh_data),
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
    .parity (sh_par),
`endif
    .done   (sh_done)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
      par_bit       <= 1'b0;
`endif
    end else begin
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (watchdog_rst) begin
        state <= ST_IDLE;
      end else if (ps2_clk_negedge) begin
        case (state)
          ST_IDLE:   if (ps2_data == PS2_START_BIT) state <= ST_DATA;
          ST_DATA:   if (sh_done) state <= ST_PARITY;
          ST_PARITY: begin
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
            par_bit <= ps2_data;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (ps2_data != PS2_STOP_BIT)
              rx_frame_err <= 1'b1;
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
            else if (!(sh_par ^ par_bit))
              rx_parity_err <= 1'b1;
`endif
            else begin
              // Same-cycle transfer frees the register, so no overrun then
              rx_data    <= sh_data;
              rx_valid   <= 1'b1;
              rx_overrun <= rx_valid & ~rx_ready;
            end
          end
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed self-checking bench for ps2_host_rx; expectations follow the
// PS2_HOST_RX_PARITY_CHECK_EN setting of the build.
module tb_ps2_host_rx;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic       watchdog_rst = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe0, fe0, ov0;

  ps2_host_rx dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .ps2_clk_negedge (ps2_clk_negedge),
    .ps2_data        (ps2_data),
    .watchdog_rst    (watchdog_rst),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_parity_err   (rx_parity_err),
    .rx_frame_err    (rx_frame_err),
    .rx_overrun      (rx_overrun),
    .rx_busy         (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse tallies let a check cover a whole frame, not just one cycle
  always @(posedge sys_clk) begin
    if (rx_parity_err) pe_cnt++;
    if (rx_frame_err)  fe_cnt++;
    if (rx_overrun)    ov_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one sample for exactly one clock
  task automatic strobe(input logic b);
    ps2_data        = b;
    ps2_clk_negedge = 1'b1;
    @(negedge sys_clk);
    ps2_clk_negedge = 1'b0;
    ps2_data        = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input logic rdy_at_stop);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(b[i]);
    strobe(p);
    rx_ready = rdy_at_stop;
    strobe(s);
    rx_ready = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
    check("consume_valid_clear", {7'd0, rx_valid}, 8'd0);
  endtask

  task automatic snap();
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_data",  rx_data, 8'h00);
    check("rst_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_busy",  {7'd0, rx_busy}, 8'd0);
    check("rst_errs",  {5'd0, rx_parity_err, rx_frame_err, rx_overrun}, 8'd0);

    // Stray edge with data 1 in IDLE
    strobe(1'b1);
    check("stray_busy", {7'd0, rx_busy}, 8'd0);

    // Good frame 0x1C, odd parity bit 0
    snap();
    strobe(1'b0);
    check("busy_rise", {7'd0, rx_busy}, 8'd1);
    for (int i = 0; i < 8; i++) strobe(i inside {2, 3, 4});
    strobe(1'b0);
    check("busy_in_frame", {7'd0, rx_busy}, 8'd1);
    strobe(1'b1);
    check("good_data",  rx_data, 8'h1C);
    check("good_valid", {7'd0, rx_valid}, 8'd1);
    check("good_busy_fall", {7'd0, rx_busy}, 8'd0);
    @(negedge sys_clk);
    check("good_no_pulses", 8'(pe_cnt - pe0 + fe_cnt - fe0 + ov_cnt - ov0), 8'd0);
    check("valid_holds", {7'd0, rx_valid}, 8'd1);
    consume();

    // 0x1C with wrong parity
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_HOST_RX_PARITY_CHECK_EN
    check("perr_pulse", {7'd0, rx_parity_err}, 8'd1);
    check("perr_valid", {7'd0, rx_valid}, 8'd0);
    @(negedge sys_clk);
    check("perr_one_cycle", {7'd0, rx_parity_err}, 8'd0);
    check("perr_count", 8'(pe_cnt - pe0), 8'd1);
`else
    check("perr_ignored_pulse", {7'd0, rx_parity_err}, 8'd0);
    check("perr_ignored_valid", {7'd0, rx_valid}, 8'd1);
    check("perr_ignored_data",  rx_data, 8'h1C);
    @(negedge sys_clk);
    consume();
`endif

    // 0xF0, correct parity 1, stop 0
    snap();
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    check("ferr_pulse",  {7'd0, rx_frame_err}, 8'd1);
    check("ferr_no_perr", {7'd0, rx_parity_err}, 8'd0);
    check("ferr_valid",  {7'd0, rx_valid}, 8'd0);
    @(negedge sys_clk);
    check("ferr_counts", 8'((fe_cnt - fe0) * 16 + (pe_cnt - pe0)), 8'h10);

    // Overrun: 0x12 unread, then 0x34
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    check("ovr_first_data", rx_data, 8'h12);
    check("ovr_first_flag", {7'd0, rx_overrun}, 8'd0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);
    check("ovr_data",  rx_data, 8'h34);
    check("ovr_pulse", {7'd0, rx_overrun}, 8'd1);
    check("ovr_valid", {7'd0, rx_valid}, 8'd1);
    @(negedge sys_clk);
    check("ovr_one_cycle", {7'd0, rx_overrun}, 8'd0);

    // Transfer in the completion cycle: no overrun
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    check("xfer_data",  rx_data, 8'h5A);
    check("xfer_valid", {7'd0, rx_valid}, 8'd1);
    check("xfer_no_ovr", {7'd0, rx_overrun}, 8'd0);
    @(negedge sys_clk);
    consume();

    // Watchdog abort after 4 data bits of 0x5A, then a full 0x5A frame
    snap();
    strobe(1'b0);
    strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
    watchdog_rst = 1'b1;
    @(negedge sys_clk);
    watchdog_rst = 1'b0;
    check("wd_busy_drop", {7'd0, rx_busy}, 8'd0);
    check("wd_valid", {7'd0, rx_valid}, 8'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("wd_after_data",  rx_data, 8'h5A);
    check("wd_after_valid", {7'd0, rx_valid}, 8'd1);
    @(negedge sys_clk);
    check("wd_no_pulses", 8'(pe_cnt - pe0 + fe_cnt - fe0 + ov_cnt - ov0), 8'd0);
    consume();

    // Watchdog coincident with a start-bit strobe discards it
    watchdog_rst = 1'b1;
    strobe(1'b0);
    watchdog_rst = 1'b0;
    check("wd_coincident_busy", {7'd0, rx_busy}, 8'd0);

    // sys_rst mid-frame with a byte pending
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("pre_rst_valid", {7'd0, rx_valid}, 8'd1);
    strobe(1'b0); strobe(1'b1); strobe(1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_data",  rx_data, 8'h00);
    check("midrst_valid", {7'd0, rx_valid}, 8'd0);
    check("midrst_busy",  {7'd0, rx_busy}, 8'd0);
    check("midrst_errs",  {5'd0, rx_parity_err, rx_frame_err, rx_overrun}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
# ps2_host_rx

Receive framer for the PS/2 host controller. It consumes the synchronized PS/2 data level, the falling-edge strobe from the clock edge detector, and the reset pulse from the clock-line watchdog. It assembles 11-bit device-to-host frames (start, 8 data bits LSB first, odd parity, stop) and presents each good byte on a valid/ready output register. Malformed frames are reported on one-cycle error pulses and are never delivered as data.

## Interface
Parameters:
- none (frame constants live in `ps2_host_pkg`)

Ports:
- `sys_clk` in 1: system clock; the only clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `ps2_clk_negedge` in 1: one-cycle strobe marking a falling edge of the synchronized PS/2 clock.
- `ps2_data` in 1: synchronized PS/2 data level, already in the `sys_clk` domain.
- `watchdog_rst` in 1: level from the clock-line watchdog; aborts any partial frame.
- `rx_ready` in 1: consumer accepts `rx_data` when `rx_valid` and `rx_ready` are both high.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_parity_err` out 1: one-cycle pulse when a frame fails odd parity.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit is sampled 0.
- `rx_overrun` out 1: one-cycle pulse when an unread byte is overwritten.
- `rx_busy` out 1: high while a frame is in progress (state is not IDLE).

## Operation
- Sampling: `ps2_data` is sampled only in cycles where `ps2_clk_negedge` is 1. No other cycle advances the FSM.
- FSM states and transitions, all on a sample:
  - IDLE: data 0 goes to DATA with the bit count cleared. Data 1 is ignored (stray edge) and raises no flag.
  - DATA: shift right into an 8-bit register, MSB in, so the LSB arrives first. The bit count increments; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: evaluate the frame, then always return to IDLE.
- Frame evaluation at the STOP sample:
  - Stop bit 0 gives `rx_frame_err`.
  - Otherwise, if XOR of the 8 data bits and the parity bit is 0, the result is `rx_parity_err`.
  - Otherwise the byte is good and is loaded into `rx_data` with `rx_valid` set.
  - Frame error takes precedence: at most one error pulse per frame.
- Output register:
  - `rx_valid` stays high until a transfer (`rx_valid & rx_ready`) clears it.
  - A good frame completing while `rx_valid` is high with no transfer in that cycle overwrites `rx_data`, keeps `rx_valid` high, and pulses `rx_overrun`.
  - A good frame completing in the same cycle as a transfer loads the new byte, keeps `rx_valid` high, and does not pulse `rx_overrun`.
  - Error frames leave `rx_data` and `rx_valid` unchanged.
- `watchdog_rst` high in any cycle forces IDLE and clears the shift register and bit count.
  - No error pulse is raised.
  - The output register is untouched.
  - If it coincides with `ps2_clk_negedge`, `watchdog_rst` wins and the sample is discarded.
- `sys_rst` clears everything: state IDLE, `rx_data` 0x00, and `rx_valid`, all error pulses and `rx_busy` at 0.

## Timing
- All outputs are registered.
- `rx_valid`, `rx_data` and the error/overrun pulses update in the cycle after the STOP sample cycle (latency 1).
- `rx_busy` rises the cycle after the start-bit sample and falls the cycle after the STOP sample.
- The consumer sees `rx_valid` fall the cycle after the accepting cycle.
- There is no minimum spacing between `ps2_clk_negedge` strobes: back-to-back strobes each advance one state.
- Reset mid-frame, by either source, takes effect on the next edge. A partially shifted byte is never visible on `rx_data`.

## Configuration
- `PS2_HOST_RX_PARITY_CHECK_EN` defined: parity is evaluated as above.
- `PS2_HOST_RX_PARITY_CHECK_EN` not defined:
  - The parity bit is still consumed as a frame position but is ignored.
  - `rx_parity_err` is tied to 0.
  - Any frame with stop bit 1 is good.

## Structure
- `ps2_host_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS` = 8;
  - the bit-count width;
  - `PS2_START_BIT` = 0 and `PS2_STOP_BIT` = 1.
- Sub-module `ps2_host_rx_shifter` holds the 8-bit shift register, the bit counter and the running parity XOR, with shift, clear and done ports. The FSM and the output register stay in `ps2_host_rx`.

## Test plan
- Good frame: 0x1C sent LSB first as start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1. Expect `rx_data` 0x1C with `rx_valid` high one cycle after the stop sample, and no error pulses.
- Parity error: 0x1C sent with parity 1. Expect a one-cycle `rx_parity_err` pulse and `rx_valid` staying 0. With the macro undefined, expect `rx_valid` with 0x1C instead.
- Frame error: 0xF0 with correct parity 1 and stop 0. Expect a `rx_frame_err` pulse only, with no `rx_parity_err` and no `rx_valid`.
- Overrun: send 0x12 with `rx_ready` held 0, then send 0x34. Expect `rx_data` 0x34, one `rx_overrun` pulse, and `rx_valid` still 1. Repeat with `rx_ready` pulsed in the completion cycle: expect no overrun.
- Watchdog abort: pulse `watchdog_rst` after 4 data bits, then send a full 0x5A frame. Expect `rx_busy` to drop, 0x5A delivered intact, and no error pulses. Also assert `watchdog_rst` coincident with a negedge and check that the sample is discarded.
- Stray edge and reset: a negedge with data 1 in IDLE leaves `rx_busy` at 0. Assert `sys_rst` mid-frame while `rx_valid` is high: all outputs go to 0 the next cycle.
